// File: rtl/dest_drain_pkg.sv
// Shared types and defaults for the destination drain controller.
// Holds the FSM state encoding and the destination tag constants.
package dest_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } drain_state_t;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    localparam int DEFAULT_DATA_W = 6;
    localparam int DEFAULT_CNT_W  = 5;

    // Number of skid entries; the credit rule keeps pops + buffered words within it.
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/drain_skid.sv
// Two-entry synchronous FIFO of {dest, data} sitting between capture and the output stream.
// Simultaneous write and read are allowed; clr empties it and zeroes the storage.
module drain_skid
    import dest_drain_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              wr_dest,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [1:0]        count,
    output logic              head_dest,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W:0] mem [SKID_DEPTH];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      cnt;
    logic            do_wr;
    logic            do_rd;

    // Guards make the buffer self-protecting even if a caller misbehaves.
    assign do_rd = rd_en && (cnt != 2'd0);
    assign do_wr = wr_en && ((cnt != 2'(SKID_DEPTH)) || do_rd);

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= {wr_dest, wr_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(do_wr) - 2'(do_rd);
        end
    end

    assign count     = cnt;
    assign head_dest = mem[rd_ptr][DATA_W];
    assign head_data = mem[rd_ptr][DATA_W-1:0];

endmodule

// File: rtl/dest_drain.sv
// Egress drain controller: pops two destination FIFOs and merges the words into one tagged stream.
// Build option DRAIN_STRICT_PRIO_EN gives d0 strict priority; otherwise d0/d1 are round-robin.
module dest_drain
    import dest_drain_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              drain_en,
    input  logic              fifo_empty_d0,
    input  logic              fifo_empty_d1,
    input  logic [DATA_W-1:0] data_d0,
    input  logic [DATA_W-1:0] data_d1,
    output logic              pop_d0,
    output logic              pop_d1,
    input  logic              sink_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_dest,
    output logic [CNT_W-1:0]  count_d0,
    output logic [CNT_W-1:0]  count_d1,
    output logic              idle
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    drain_state_t      state;
    logic              clr;
    logic              vld_p0;
    logic              tag_p0;
    logic [DATA_W-1:0] cap_data_p0;
    logic [1:0]        skid_count;
    logic              accept;
    logic [2:0]        credit;
    logic              can_pop;
    logic              grant_d0;
    logic              grant_d1;
    logic              drained;

    assign clr = reset | init;

    assign out_valid = (skid_count != 2'd0);
    assign accept    = out_valid & sink_ready;

    // A word leaving this cycle frees its slot, which is what lets pops resume as sink_ready rises.
    assign credit  = 3'(skid_count) + 3'(vld_p0) - 3'(accept);
    assign can_pop = (state == ST_ACTIVE) && drain_en && !clr && (credit < 3'd2);

    assign drained = fifo_empty_d0 && fifo_empty_d1 && !vld_p0 && (skid_count == 2'd0);

`ifdef DRAIN_STRICT_PRIO_EN
    always_comb begin
        grant_d0 = 1'b0;
        grant_d1 = 1'b0;
        if (!fifo_empty_d0) begin
            grant_d0 = 1'b1;
        end else if (!fifo_empty_d1) begin
            grant_d1 = 1'b1;
        end
    end
`else
    logic last_grant;

    always_comb begin
        grant_d0 = 1'b0;
        grant_d1 = 1'b0;
        if (!fifo_empty_d0 && !fifo_empty_d1) begin
            grant_d0 = (last_grant == DEST_D1);
            grant_d1 = (last_grant == DEST_D0);
        end else if (!fifo_empty_d0) begin
            grant_d0 = 1'b1;
        end else if (!fifo_empty_d1) begin
            grant_d1 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant <= DEST_D1;
        end else if (pop_d0 || pop_d1) begin
            last_grant <= pop_d1 ? DEST_D1 : DEST_D0;
        end
    end
`endif

    assign pop_d0 = can_pop & grant_d0;
    assign pop_d1 = can_pop & grant_d1;

    // ---- stage p0: pop issued last cycle, read data returns now ----
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_p0 <= 1'b0;
            tag_p0 <= DEST_D0;
        end else begin
            vld_p0 <= pop_d0 | pop_d1;
            tag_p0 <= pop_d1 ? DEST_D1 : DEST_D0;
        end
    end

    assign cap_data_p0 = (tag_p0 == DEST_D1) ? data_d1 : data_d0;

    // ---- stage p1: skid buffer feeding the output stream ----
    drain_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .clr       (clr),
        .wr_en     (vld_p0),
        .wr_dest   (tag_p0),
        .wr_data   (cap_data_p0),
        .rd_en     (accept),
        .count     (skid_count),
        .head_dest (out_dest),
        .head_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (drain_en && (!fifo_empty_d0 || !fifo_empty_d1)) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (drained) begin
                        state <= ST_IDLE;
                    end else if (!drain_en) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (drain_en) begin
                        state <= ST_ACTIVE;
                    end else if (drained) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign idle = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            count_d0 <= '0;
            count_d1 <= '0;
        end else if (accept) begin
            if (out_dest == DEST_D1) begin
                count_d1 <= sat_inc(count_d1);
            end else begin
                count_d0 <= sat_inc(count_d0);
            end
        end
    end

endmodule

// File: tb/tb_dest_drain.sv
// Scoreboard bench for dest_drain: the bench plays both destination FIFOs and checks the merged stream.
// Define DRAIN_STRICT_PRIO_EN for both DUT and bench to check the strict-priority build.
module tb_dest_drain;

    localparam int DATA_W  = 6;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              init = 1'b0;
    logic              drain_en = 1'b1;
    logic              fifo_empty_d0 = 1'b1;
    logic              fifo_empty_d1 = 1'b1;
    logic [DATA_W-1:0] data_d0 = '0;
    logic [DATA_W-1:0] data_d1 = '0;
    logic              sink_ready = 1'b1;
    logic              pop_d0;
    logic              pop_d1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_dest;
    logic [CNT_W-1:0]  count_d0;
    logic [CNT_W-1:0]  count_d1;
    logic              idle;

    dest_drain #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .drain_en      (drain_en),
        .fifo_empty_d0 (fifo_empty_d0),
        .fifo_empty_d1 (fifo_empty_d1),
        .data_d0       (data_d0),
        .data_d1       (data_d1),
        .pop_d0        (pop_d0),
        .pop_d1        (pop_d1),
        .sink_ready    (sink_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_dest      (out_dest),
        .count_d0      (count_d0),
        .count_d1      (count_d1),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench-side FIFO contents and per-destination expected words.
    logic [DATA_W-1:0] fq0[$];
    logic [DATA_W-1:0] fq1[$];
    logic [DATA_W-1:0] exp0[$];
    logic [DATA_W-1:0] exp1[$];
    logic [DATA_W:0]   acc_log[$];
    int                acc_cyc[$];

    int   cyc = 0;
    int   pop_total = 0;
    int   outstanding = 0;
    int   m_cnt0 = 0;
    int   m_cnt1 = 0;
    logic m_last = 1'b1;
    logic exp_g;
    logic prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_dest = 1'b0;
    logic last_p0 = 1'b0;
    logic last_p1 = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (reset || init) begin
            chk("pop_during_reset", int'({pop_d0, pop_d1}), 0);
            m_cnt0      = 0;
            m_cnt1      = 0;
            outstanding = 0;
            m_last      = 1'b1;
            prev_hold   = 1'b0;
        end else begin
            chk("count_d0", int'(count_d0), m_cnt0);
            chk("count_d1", int'(count_d1), m_cnt1);
            if (pop_d0 || pop_d1) begin
                chk("single_pop", int'(pop_d0 && pop_d1), 0);
                chk("pop_d0_while_empty", int'(pop_d0 && fifo_empty_d0), 0);
                chk("pop_d1_while_empty", int'(pop_d1 && fifo_empty_d1), 0);
                chk("pop_without_drain_en", int'(drain_en), 1);
`ifdef DRAIN_STRICT_PRIO_EN
                exp_g = fifo_empty_d0;
`else
                exp_g = (!fifo_empty_d0 && !fifo_empty_d1) ? ~m_last : fifo_empty_d0;
`endif
                chk("arbitration_grant", int'(pop_d1), int'(exp_g));
                m_last = pop_d1;
                pop_total++;
            end
            if (prev_hold) begin
                chk("held_valid", int'(out_valid), 1);
                chk("held_data", int'(out_data), int'(prev_data));
                chk("held_dest", int'(out_dest), int'(prev_dest));
            end
            if (out_valid && sink_ready) begin
                if (out_dest) begin
                    if (exp1.size() == 0) chk("unexpected_d1_word", int'(out_data), -1);
                    else chk("data_d1", int'(out_data), int'(exp1.pop_front()));
                    if (m_cnt1 < CNT_MAX) m_cnt1++;
                end else begin
                    if (exp0.size() == 0) chk("unexpected_d0_word", int'(out_data), -1);
                    else chk("data_d0", int'(out_data), int'(exp0.pop_front()));
                    if (m_cnt0 < CNT_MAX) m_cnt0++;
                end
                acc_log.push_back({out_dest, out_data});
                acc_cyc.push_back(cyc);
            end
            outstanding = outstanding + int'(pop_d0 || pop_d1) - int'(out_valid && sink_ready);
            chk("words_outstanding_le_2", int'(outstanding <= 2), 1);
            prev_hold = out_valid && !sink_ready;
            prev_data = out_data;
            prev_dest = out_dest;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic upd_flags();
        fifo_empty_d0 = (fq0.size() == 0);
        fifo_empty_d1 = (fq1.size() == 0);
    endtask

    task automatic tick();
        logic p0, p1;
        @(negedge clk);
        p0 = pop_d0;
        p1 = pop_d1;
        @(posedge clk);
        #1;
        last_p0 = p0;
        last_p1 = p1;
        if (p0 && fq0.size() > 0) data_d0 = fq0.pop_front();
        if (p1 && fq1.size() > 0) data_d1 = fq1.pop_front();
        upd_flags();
    endtask

    task automatic push(input logic d, input logic [4:0] v);
        logic [DATA_W-1:0] w;
        w = {d, v};
        if (d) begin
            fq1.push_back(w);
            exp1.push_back(w);
        end else begin
            fq0.push_back(w);
            exp0.push_back(w);
        end
        upd_flags();
    endtask

    task automatic flush();
        fq0.delete();
        fq1.delete();
        exp0.delete();
        exp1.delete();
        upd_flags();
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (idle && fq0.size() == 0 && fq1.size() == 0) done = 1'b1;
        end
        chk(nm, int'(done), 1);
    endtask

    task automatic chk_reset_vals(input string nm);
        #1;
        chk({nm, "_pops"}, int'({pop_d0, pop_d1}), 0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_out_data"}, int'(out_data), 0);
        chk({nm, "_out_dest"}, int'(out_dest), 0);
        chk({nm, "_counts"}, int'({count_d0, count_d1}), 0);
        chk({nm, "_idle"}, int'(idle), 1);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        flush();
        tick();
        init = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W:0] exp_seq [4];
        int base;
        int drop;
        int n;
        bit found;

        repeat (3) tick();
        reset = 1'b0;
        chk_reset_vals("reset_values");

        // Both FIFOs preloaded, sink always ready.
        acc_log.delete();
        acc_cyc.delete();
        push(0, 5'h01);
        push(0, 5'h02);
        push(1, 5'h01);
        push(1, 5'h02);
`ifdef DRAIN_STRICT_PRIO_EN
        exp_seq = '{7'h01, 7'h02, 7'h61, 7'h62};
`else
        exp_seq = '{7'h01, 7'h61, 7'h02, 7'h62};
`endif
        wait_idle("preload_idle_return");
        chk("preload_accepts", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            chk("preload_order", int'(acc_log[i]), int'(exp_seq[i]));
            chk("preload_back_to_back", acc_cyc[i] - acc_cyc[0], i);
        end
        chk("preload_count_d0", int'(count_d0), 2);
        chk("preload_count_d1", int'(count_d1), 2);

        // Backpressure: only two words may be taken while the sink stalls.
        acc_log.delete();
        sink_ready = 1'b0;
        base = pop_total;
        for (int i = 0; i < 4; i++) push(0, 5'(3 + i));
        repeat (10) tick();
        chk("backpressure_pops", pop_total - base, 2);
        chk("backpressure_no_accept", acc_log.size(), 0);
        sink_ready = 1'b1;
        wait_idle("backpressure_idle");
        chk("backpressure_total_pops", pop_total - base, 4);
        chk("backpressure_accepts", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            chk("backpressure_order", int'(acc_log[i]), 3 + i);

        // Reset the cycle after a pop: the returning word must be dropped.
        acc_log.delete();
        push(0, 5'h0A);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (last_p0) found = 1'b1;
        end
        chk("midflight_pop_seen", int'(found), 1);
        reset = 1'b1;
        flush();
        tick();
        reset = 1'b0;
        chk_reset_vals("midflight_reset");
        repeat (6) tick();
        chk("midflight_word_discarded", acc_log.size(), 0);

        // drain_en drops while busy: pops stop, in-flight and buffered words still emerge.
        acc_log.delete();
        base = pop_total;
        for (int i = 0; i < 4; i++) push(0, 5'(8 + i));
        n = 0;
        while ((pop_total - base) < 2 && n < 20) begin
            tick();
            n++;
        end
        drain_en = 1'b0;
        drop = pop_total;
        repeat (6) tick();
        chk("hold_no_new_pops", pop_total, drop);
        chk("hold_inflight_emerged", acc_log.size(), drop - base);
        chk("hold_not_idle", int'(idle), 0);
        drain_en = 1'b1;
        wait_idle("hold_resume_idle");
        chk("hold_total_accepts", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            chk("hold_order", int'(acc_log[i]), 8 + i);

        // Counter saturation at 2^CNT_W-1, then cleared by init.
        pulse_init();
        for (int i = 0; i < 5; i++) push(1, 5'(16 + i));
        wait_idle("sat_idle");
        chk("sat_count_d1", int'(count_d1), CNT_MAX);
        chk("sat_count_d0", int'(count_d0), 0);
        pulse_init();
        #1;
        chk("init_clears_d0", int'(count_d0), 0);
        chk("init_clears_d1", int'(count_d1), 0);

        // Randomised traffic, checked continuously by the monitor.
        for (int c = 0; c < 1500; c++) begin
            tick();
            init = 1'b0;
            sink_ready = ($urandom_range(0, 3) != 0);
            drain_en   = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 1) == 0) begin
                logic d;
                d = 1'($urandom_range(0, 1));
                if ((d ? fq1.size() : fq0.size()) < 6) push(d, 5'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 199) == 0) begin
                init = 1'b1;
                flush();
            end
        end
        init = 1'b0;
        drain_en = 1'b1;
        sink_ready = 1'b1;
        wait_idle("random_final_idle");
        chk("random_exp0_drained", exp0.size(), 0);
        chk("random_exp1_drained", exp1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
